// File: rtl/memory_map_pkg.sv
// Shared address map and bus-state definitions for the core-local peripherals.
//
// Contents:
//   MsipAddr / MtimecmpAddr / MtimeAddr : byte offsets of the CLINT registers
//   MtimecmpHiAddr / MtimeHiAddr        : high-word offsets used on a 32-bit bus
//   clint_state_t                       : CLINT bus handshake states (IDLE, ACK)
package memory_map_pkg;

  localparam logic [15:0] MsipAddr       = 16'h0000;
  localparam logic [15:0] MtimecmpAddr   = 16'h4000;
  localparam logic [15:0] MtimecmpHiAddr = 16'h4004;
  localparam logic [15:0] MtimeAddr      = 16'hBFF8;
  localparam logic [15:0] MtimeHiAddr    = 16'hBFFC;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } clint_state_t;

endpackage

// File: rtl/byte_en_register.sv
// Register of width N with one write enable per byte and a configurable reset value.
//
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high reset (loads RESET_VALUE)
//   be    : per-byte write enables, bit i enables byte i of d
//   d     : next value for the enabled bytes
//   q     : current register value
module byte_en_register #(
  parameter int N = 64,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N/8-1:0] be,
  input  logic [N-1:0]   d,
  output logic [N-1:0]   q
);

  // Each enabled byte takes its slice of d; disabled bytes keep their value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else begin
      for (int i = 0; i < N/8; i++) begin
        if (be[i]) begin
          q[i*8 +: 8] <= d[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/core_local_interruptor.sv
// Core-local interruptor: software interrupt bit, 64-bit real-time counter and
// its comparator, exposed as a Wishbone-style bus slave and fed to the CSR file.
//
// Ports:
//   clock, reset         : system clock, asynchronous active-high reset
//   wb_cyc, wb_stb       : bus cycle / strobe; a request is taken when both are high
//   wb_we                : 1 = write, 0 = read
//   wb_addr              : byte offset within the block
//   wb_sel               : byte lane enables
//   wb_dat_i / wb_dat_o  : write data / registered read data
//   wb_ack               : one-cycle acknowledge, one cycle after acceptance
//   msip                 : machine software interrupt pending
//   mtime, mtimecmp      : timer value and comparator (64 bits on either bus width)
module core_local_interruptor
  import memory_map_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CLOCK_CYCLES = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb_cyc,
  input  logic                   wb_stb,
  input  logic                   wb_we,
  input  logic [15:0]            wb_addr,
  input  logic [DATA_SIZE/8-1:0] wb_sel,
  input  logic [DATA_SIZE-1:0]   wb_dat_i,
  output logic [DATA_SIZE-1:0]   wb_dat_o,
  output logic                   wb_ack,
  output logic                   msip,
  output logic [63:0]            mtime,
  output logic [63:0]            mtimecmp
);

  localparam int PRESC_W = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLOCK_CYCLES - 1);

  clint_state_t state, next_state;

  logic                 accept;
  logic                 write;
  logic                 read;
  logic                 hit_msip;
  logic [63:0]          wr_data;
  logic [7:0]           cmp_be;
  logic [7:0]           time_be_bus;
  logic [DATA_SIZE-1:0] rd_data;

  logic [PRESC_W-1:0]   prescaler;
  logic                 tick;
  logic                 time_write;
  logic [7:0]           time_be;
  logic [63:0]          time_d;

  // A request is only taken in IDLE, so a held strobe yields one access per two cycles.
  assign accept = (state == IDLE) && wb_cyc && wb_stb;
  assign write  = accept && wb_we;
  assign read   = accept && !wb_we;

  // Bus-width specific decode: maps the bus lanes onto the 64-bit registers
  // as byte enables and builds the read value for the addressed word.
  if (DATA_SIZE == 64) begin : g_bus64
    localparam logic [15:0] Mask = 16'hFFF8;
    logic hit_cmp;
    logic hit_time;

    assign hit_msip    = (wb_addr & Mask) == MsipAddr;
    assign hit_cmp     = (wb_addr & Mask) == MtimecmpAddr;
    assign hit_time    = (wb_addr & Mask) == MtimeAddr;
    assign wr_data     = wb_dat_i;
    assign cmp_be      = (write && hit_cmp)  ? wb_sel : 8'h00;
    assign time_be_bus = (write && hit_time) ? wb_sel : 8'h00;

    // Read mux; unmapped offsets return zero.
    always_comb begin
      rd_data = '0;
      if (hit_msip) begin
        rd_data[0] = msip;
      end else if (hit_cmp) begin
        rd_data = mtimecmp;
      end else if (hit_time) begin
        rd_data = mtime;
      end
    end
  end else begin : g_bus32
    localparam logic [15:0] Mask = 16'hFFFC;
    logic hit_cmp_lo;
    logic hit_cmp_hi;
    logic hit_time_lo;
    logic hit_time_hi;

    assign hit_msip    = (wb_addr & Mask) == MsipAddr;
    assign hit_cmp_lo  = (wb_addr & Mask) == MtimecmpAddr;
    assign hit_cmp_hi  = (wb_addr & Mask) == MtimecmpHiAddr;
    assign hit_time_lo = (wb_addr & Mask) == MtimeAddr;
    assign hit_time_hi = (wb_addr & Mask) == MtimeHiAddr;
    assign wr_data     = {wb_dat_i, wb_dat_i};
    assign cmp_be      = {(write && hit_cmp_hi)  ? wb_sel : 4'h0,
                          (write && hit_cmp_lo)  ? wb_sel : 4'h0};
    assign time_be_bus = {(write && hit_time_hi) ? wb_sel : 4'h0,
                          (write && hit_time_lo) ? wb_sel : 4'h0};

    // Read mux; each half of a 64-bit register is its own word.
    always_comb begin
      rd_data = '0;
      if (hit_msip) begin
        rd_data[0] = msip;
      end else if (hit_cmp_lo) begin
        rd_data = mtimecmp[31:0];
      end else if (hit_cmp_hi) begin
        rd_data = mtimecmp[63:32];
      end else if (hit_time_lo) begin
        rd_data = mtime[31:0];
      end else if (hit_time_hi) begin
        rd_data = mtime[63:32];
      end
    end
  end

  // Handshake state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake next state: IDLE waits for a request, ACK always returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered acknowledge and read data; read data holds until the next read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack <= accept;
      if (read) begin
        wb_dat_o <= rd_data;
      end
    end
  end

  // Software interrupt bit: only bit 0 of the MSIP word exists.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      msip <= 1'b0;
    end else if (write && hit_msip && wb_sel[0]) begin
      msip <= wr_data[0];
    end
  end

  assign time_write = |time_be_bus;
  assign tick       = (prescaler == PRESC_MAX);

  // Prescaler: wraps every CLOCK_CYCLES cycles, and restarts whenever software
  // writes any byte of mtime so the next tick is a full period away.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (time_write || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRESC_W'(1);
    end
  end

  // A bus write to mtime overrides the tick: written bytes take bus data and
  // the rest keep their old value with no increment.
  assign time_be = time_write ? time_be_bus : {8{tick}};
  assign time_d  = time_write ? wr_data : mtime + 64'd1;

  byte_en_register #(
    .N           (64),
    .RESET_VALUE ({64{1'b1}})
  ) u_mtimecmp (
    .clock (clock),
    .reset (reset),
    .be    (cmp_be),
    .d     (wr_data),
    .q     (mtimecmp)
  );

  byte_en_register #(
    .N           (64),
    .RESET_VALUE ('0)
  ) u_mtime (
    .clock (clock),
    .reset (reset),
    .be    (time_be),
    .d     (time_d),
    .q     (mtime)
  );

endmodule
